// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive stages.
//   tx_state_e : FSM state encodings (IDLE/START/DATA/PARITY/STOP)
//   FRAME_BITS : serial bits per frame (10, or 11 when TX_PARITY_EN is defined)
//   IDLE_LVL   : serial line level between frames
// Configuration macro: TX_PARITY_EN (adds an even-parity bit between D7 and stop).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

`ifdef TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  localparam logic IDLE_LVL = 1'b1;

  // Baud period as used by the bit timer: a programmed 0 behaves as 1.
  function automatic logic [19:0] baud_eff(input logic [19:0] b);
    return (b == 20'd0) ? 20'd1 : b;
  endfunction

endpackage

// File: rtl/PipeReg.sv
// PipeReg: plain W-bit register with synchronous active-high reset to RST_VAL.
// Ports:
//   i_clk  in  1  clock
//   i_rst  in  1  synchronous reset, active high
//   i_d    in  W  next value
//   o_q    out W  registered value
module PipeReg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= RST_VAL;
    else       r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: bit timer for the UART transmitter. Counts clk cycles while
// enabled and fires o_bit_tick in the last cycle of each bit period, then wraps.
// Ports:
//   i_clk      in  1       clock
//   i_rst      in  1       synchronous reset, active high
//   i_baud_l   in  BAUD_W  latched bit period in clk cycles (never 0)
//   i_enable   in  1       count while high (a frame is in progress)
//   i_clear    in  1       restart the bit period from 0
//   o_bit_tick out 1       high in the final cycle of the current bit
module baud_tick_gen #(
  parameter int BAUD_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BAUD_W-1:0] i_baud_l,
  input  logic              i_enable,
  input  logic              i_clear,
  output logic              o_bit_tick
);

  logic [BAUD_W-1:0] r_baud_cnt;
  logic              w_tick;

  assign w_tick     = i_enable & (r_baud_cnt == (i_baud_l - BAUD_W'(1)));
  assign o_bit_tick = w_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || w_tick) r_baud_cnt <= '0;
    else if (i_enable)              r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
  end

endmodule

// File: rtl/tx_eight_ten.sv
// tx_eight_ten: UART transmit stage. Accepts a byte on a valid/ready handshake,
// frames it as start(0), D0..D7 LSB first, [even parity], stop(1) and drives it
// on tx_out at baud clk cycles per bit.
// Configuration macro: TX_PARITY_EN inserts the even-parity bit (11-bit frame).
// Ports:
//   clk       in   1       system clock, rising edge
//   rst       in   1       synchronous reset, active high
//   baud      in   BAUD_W  clk cycles per bit, 0 treated as 1 (latched at accept)
//   tx_en     in   1       gates acceptance of new bytes only
//   tx_valid  in   1       tx_data holds a byte to send
//   tx_data   in   DATA_W  byte to send (latched at accept)
//   tx_ready  out  1       byte can be accepted this cycle
//   tx_out    out  1       serial line, registered, idle high
//   tx_busy   out  1       frame in progress
//   tx_done   out  1       pulse in the last cycle of the stop bit
//   dbg_state out  3       current FSM state (tx_state_e encoding)
// Handshake: a byte is taken on every rising edge where tx_valid & tx_ready;
// tx_ready depends only on state/tx_en/rst, never on tx_valid. No buffering:
// tx_valid while not ready is ignored.
module tx_eight_ten
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BAUD_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BAUD_W-1:0] baud,
  input  logic              tx_en,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done,
  output logic [2:0]        dbg_state
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_e         w_state;
  tx_state_e         w_state_nxt;
  logic [2:0]        r_state_bits;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [BAUD_W-1:0] r_baud_l;
  logic [BAUD_W-1:0] w_baud_l_nxt;
  logic              r_line;
  logic              w_line_nxt;
  logic              w_accept;
  logic              w_bit_tick;
  logic              w_running;

  assign w_state   = tx_state_e'(r_state_bits);
  assign w_running = (w_state != ST_IDLE);

  assign tx_ready  = (w_state == ST_IDLE) & tx_en & ~rst;
  assign w_accept  = tx_valid & tx_ready;
  assign tx_out    = r_line;
  assign tx_busy   = w_running & ~rst;
  assign tx_done   = (w_state == ST_STOP) & w_bit_tick & ~rst;
  assign dbg_state = r_state_bits;

`ifdef TX_PARITY_EN
  logic r_par;
  logic w_par_nxt;
`endif

  always_comb begin
    w_state_nxt  = w_state;
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_baud_l_nxt = r_baud_l;
`ifdef TX_PARITY_EN
    w_par_nxt    = r_par;
`endif
    case (w_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt  = ST_START;
          w_shift_nxt  = tx_data;
          w_idx_nxt    = '0;
          w_baud_l_nxt = (baud == '0) ? BAUD_W'(1) : baud;
`ifdef TX_PARITY_EN
          w_par_nxt    = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (w_bit_tick) begin
          w_state_nxt = ST_DATA;
          w_idx_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (w_bit_tick) begin
          if (r_idx == IDX_W'(DATA_W - 1)) begin
`ifdef TX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end else begin
            // The current bit always sits in r_shift[0].
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_shift_nxt = r_shift >> 1;
          end
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_tick) w_state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_bit_tick) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Line level is decided from the next state so the registered output
    // changes on the same edge as the state (start bit one cycle after accept).
    case (w_state_nxt)
      ST_START: w_line_nxt = 1'b0;
      ST_DATA:  w_line_nxt = w_shift_nxt[0];
`ifdef TX_PARITY_EN
      ST_PARITY: w_line_nxt = w_par_nxt;
`endif
      default:  w_line_nxt = IDLE_LVL;
    endcase
  end

  PipeReg #(.W(3), .RST_VAL(ST_IDLE)) u_state_reg (
    .i_clk(clk), .i_rst(rst), .i_d(w_state_nxt), .o_q(r_state_bits)
  );

  PipeReg #(.W(IDX_W), .RST_VAL('0)) u_idx_reg (
    .i_clk(clk), .i_rst(rst), .i_d(w_idx_nxt), .o_q(r_idx)
  );

  PipeReg #(.W(DATA_W), .RST_VAL('0)) u_shift_reg (
    .i_clk(clk), .i_rst(rst), .i_d(w_shift_nxt), .o_q(r_shift)
  );

  PipeReg #(.W(BAUD_W), .RST_VAL(BAUD_W'(1))) u_baud_reg (
    .i_clk(clk), .i_rst(rst), .i_d(w_baud_l_nxt), .o_q(r_baud_l)
  );

  PipeReg #(.W(1), .RST_VAL(IDLE_LVL)) u_line_reg (
    .i_clk(clk), .i_rst(rst), .i_d(w_line_nxt), .o_q(r_line)
  );

`ifdef TX_PARITY_EN
  PipeReg #(.W(1), .RST_VAL(1'b0)) u_par_reg (
    .i_clk(clk), .i_rst(rst), .i_d(w_par_nxt), .o_q(r_par)
  );
`endif

  baud_tick_gen #(.BAUD_W(BAUD_W)) u_baud_tick (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_baud_l   (w_baud_l_nxt),
    .i_enable   (w_running),
    .i_clear    (w_accept),
    .o_bit_tick (w_bit_tick)
  );

endmodule

// File: tb/tb_tx_eight_ten.sv
// tb_tx_eight_ten: directed bench for tx_eight_ten. A table of frames with
// hand-computed line patterns is sent and checked cycle by cycle, followed by
// hand-written sequences for back-to-back frames, tx_en drop and mid-frame reset.
module tb_tx_eight_ten;
  import uart_pkg::*;

  logic        clk;
  logic        rst;
  logic [19:0] baud;
  logic        tx_en;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_out;
  logic        tx_busy;
  logic        tx_done;
  logic [2:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  tx_eight_ten #(.DATA_W(8), .BAUD_W(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud      (baud),
    .tx_en     (tx_en),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .tx_out    (tx_out),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // frame vector: fr holds the 10 start/data/stop bits, bit i = i-th bit sent
  typedef struct {
    logic [19:0] baud_in;
    int          bl;
    logic [7:0]  data;
    logic [9:0]  fr;
    logic        par;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bit_at(input int pos, input logic [9:0] fr, input logic par);
    if (pos < 9) return fr[pos];
`ifdef TX_PARITY_EN
    if (pos == 9) return par;
`endif
    return 1'b1;
  endfunction

  // driver: present a byte, check ready, let the edge accept it, then scramble
  // the inputs so the frame must come from latched copies.
  task automatic do_accept(input logic [19:0] b, input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    baud     = b;
    chk("ready_before_accept", tx_ready, 1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = ~d;
    baud     = 20'd7;
  endtask

  // checks every cycle of one frame after the accept edge, then the idle cycle
  task automatic check_frame(input int bl, input logic [9:0] fr, input logic par,
                             input int drop_at);
    int total;
    total = FRAME_BITS * bl;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (k == drop_at) tx_en = 1'b0;
      chk("tx_out_bit", tx_out, bit_at((k - 1) / bl, fr, par));
      chk("tx_busy_frame", tx_busy, 1);
      chk("tx_ready_frame", tx_ready, 0);
      chk("tx_done_pos", tx_done, (k == total) ? 1 : 0);
    end
    @(negedge clk);
    chk("idle_tx_out", tx_out, 1);
    chk("idle_tx_busy", tx_busy, 0);
    chk("idle_tx_done", tx_done, 0);
  endtask

  initial begin
    vecs[0] = '{baud_in: 20'd4, bl: 4, data: 8'hA5, fr: 10'b1101001010, par: 1'b0};
    vecs[1] = '{baud_in: 20'd0, bl: 1, data: 8'h00, fr: 10'b1000000000, par: 1'b0};
    vecs[2] = '{baud_in: 20'd1, bl: 1, data: 8'h3C, fr: 10'b1001111000, par: 1'b0};
    vecs[3] = '{baud_in: 20'd3, bl: 3, data: 8'h81, fr: 10'b1100000010, par: 1'b0};
    vecs[4] = '{baud_in: 20'd2, bl: 2, data: 8'h07, fr: 10'b1000001110, par: 1'b1};
    vecs[5] = '{baud_in: 20'd5, bl: 5, data: 8'hC3, fr: 10'b1110000110, par: 1'b0};

    rst      = 1'b1;
    tx_en    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    baud     = 20'd4;

    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_tx_done", tx_done, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tx_out", tx_out, 1);
    chk("post_rst_tx_ready", tx_ready, 1);
    chk("post_rst_tx_busy", tx_busy, 0);
    chk("post_rst_tx_done", tx_done, 0);
    chk("post_rst_state", dbg_state, 3'd0);

    // table-driven frames
    for (int i = 0; i < 6; i++) begin
      do_accept(vecs[i].baud_in, vecs[i].data);
      check_frame(vecs[i].bl, vecs[i].fr, vecs[i].par, 0);
      chk("ready_after_frame", tx_ready, 1);
    end

    // back-to-back: tx_valid held high, 0x55 then 0xFF at baud 2
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    baud     = 20'd2;
    chk("b2b_ready_first", tx_ready, 1);
    @(posedge clk);
    #1;
    tx_data = 8'hFF;
    baud    = 20'd9;
    // 0x55 must still be sent at baud 2; its idle cycle is cycle FRAME_BITS*2+1
    check_frame(2, 10'b1010101010, 1'b0, 0);
    chk("b2b_ready_second", tx_ready, 1);
    baud = 20'd2;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    baud     = 20'd7;
    check_frame(2, 10'b1111111110, 1'b0, 0);

    // tx_en dropped in cycle 15 of a baud 3 frame with another byte pending
    do_accept(20'd3, 8'hC3);
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    check_frame(3, 10'b1110000110, 1'b0, 15);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("en_off_ready", tx_ready, 0);
      chk("en_off_busy", tx_busy, 0);
      chk("en_off_tx_out", tx_out, 1);
    end
    tx_valid = 1'b0;
    tx_en    = 1'b1;

    // reset during DATA (cycle 5 of a baud 2 frame carries D1)
    do_accept(20'd2, 8'h07);
    repeat (4) @(negedge clk);
    @(negedge clk);
    chk("pre_rst_state_data", dbg_state, 3'd2);
    chk("pre_rst_tx_out_d1", tx_out, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx_out", tx_out, 1);
    chk("mid_rst_tx_busy", tx_busy, 0);
    chk("mid_rst_tx_done", tx_done, 0);
    chk("mid_rst_state", dbg_state, 3'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("after_rst_tx_done", tx_done, 0);
      chk("after_rst_tx_out", tx_out, 1);
      chk("after_rst_ready", tx_ready, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
